mux_rr_arb: RTL

MUX_RR_ARB -- requirements
Module: mux_rr_arb

---
 rtl/mux_rr_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N-channel valid/ready multiplexer with a single registered output
// stage. Mode 0 arbitrates round-robin from a rotating pointer; mode 1 passes the
// channel named by sel. A new word can enter the output register in the same
// edge that the old one drains, so a continuously ready sink sees one word per
// cycle.
module mux_rr_arb #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NCH*WIDTH-1:0]      in_data,
    input  logic [NCH-1:0]            in_valid,
    output logic [NCH-1:0]            in_ready,
    input  logic                      mode,
    input  logic [$clog2(NCH)-1:0]    sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(NCH)-1:0]    out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int CW = $clog2(NCH);

    // Channel count at CW+1 bits, so that index sums and range checks never overflow.
    localparam logic [CW:0] NCH_W  = (CW+1)'(NCH);
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    // Output register and round-robin pointer.
    logic [WIDTH-1:0] r_out_data;
    logic [CW-1:0]    r_out_sel;
    logic             r_out_valid;
    logic [CW-1:0]    r_ptr;

    // Combinational arbitration results.
    logic             w_load;
    logic             w_rr_hit;
    logic [CW-1:0]    w_rr_idx;
    logic             w_fx_hit;
    logic             w_gnt_hit;
    logic [CW-1:0]    w_gnt_idx;
    logic             w_transfer;
    logic [WIDTH-1:0] w_gnt_data;
    logic [NCH-1:0]   w_in_ready;
    logic [CW-1:0]    w_ptr_next;

    // The output register may accept a word when it is empty or being drained.
    assign w_load = ~r_out_valid | out_ready;

    // Round-robin search: first valid channel at or above the pointer, wrapping at NCH.
    always_comb begin : p_rr_search
        logic [CW:0]   v_cand;
        logic [CW-1:0] v_idx;
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            v_cand = {1'b0, r_ptr} + (CW+1)'(k);
            if (v_cand >= NCH_W) begin
                v_cand = v_cand - NCH_W;
            end else begin
                v_cand = v_cand;
            end
            v_idx = v_cand[CW-1:0];
            if (!w_rr_hit && in_valid[v_idx]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = v_idx;
            end else begin
                w_rr_hit = w_rr_hit;
            end
        end
    end

    // Fixed selection: only an in-range, valid sel is granted.
    always_comb begin
        w_fx_hit = 1'b0;
        if ({1'b0, sel} < NCH_W) begin
            w_fx_hit = in_valid[sel];
        end else begin
            w_fx_hit = 1'b0;
        end
    end

    // Pick the grant source according to the mode sampled this cycle.
    always_comb begin
        w_gnt_hit = 1'b0;
        w_gnt_idx = '0;
        case (mode)
            1'b0: begin
                w_gnt_hit = w_rr_hit;
                w_gnt_idx = w_rr_idx;
            end
            1'b1: begin
                w_gnt_hit = w_fx_hit;
                w_gnt_idx = sel;
            end
            default: begin
                w_gnt_hit = 1'b0;
                w_gnt_idx = '0;
            end
        endcase
    end

    assign w_transfer = w_load & w_gnt_hit;

    // Data mux: only the granted lane contributes, other lanes are never observed.
    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_gnt_hit && (w_gnt_idx == CW'(i))) begin
                w_gnt_data = in_data[i*WIDTH +: WIDTH];
            end else begin
                w_gnt_data = w_gnt_data;
            end
        end
    end

    // Ready goes back only to the granted channel, only when the output can load, never in reset.
    always_comb begin
        w_in_ready = '0;
        if (rst_n && w_transfer) begin
            w_in_ready[w_gnt_idx] = 1'b1;
        end else begin
            w_in_ready = '0;
        end
    end

    // Next pointer: one past the winner, wrapping from the last channel to zero.
    always_comb begin
        w_ptr_next = r_ptr;
        if (w_transfer && !mode) begin
            if (w_gnt_idx == LAST) begin
                w_ptr_next = '0;
            end else begin
                w_ptr_next = w_gnt_idx + CW'(1);
            end
        end else begin
            w_ptr_next = r_ptr;
        end
    end

    // Output register: load on transfer, empty on an idle load, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_transfer) begin
            r_out_data  <= w_gnt_data;
            r_out_sel   <= w_gnt_idx;
            r_out_valid <= 1'b1;
        end else if (w_load) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule
